// File: rtl/dds_pkg.sv
// Shared types, widths and step arithmetic for the DDS chirp controller.
package dds_pkg;

   localparam int unsigned DDS_ACC_W  = 48;
   localparam int unsigned DDS_OUT_W  = 16;
   localparam int unsigned DDS_RATE_W = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      STOP = 2'd3
   } dds_state_e;

   // Step parameters captured at LOAD and held for the whole burst.
   typedef struct packed {
      logic [DDS_ACC_W-1:0]  delta;
      logic [DDS_RATE_W-1:0] rate;
   } dds_step_cfg_t;

   // Unsigned tuning word plus signed increment; returns {sat, result}.
   // Carry out of the ACC_W+1 sum means out of range, delta's sign gives the side.
   function automatic logic [DDS_ACC_W:0] sat_add(
      input logic [DDS_ACC_W-1:0] ftw,
      input logic [DDS_ACC_W-1:0] delta,
      input logic                 sat_en
   );
      logic [DDS_ACC_W:0] sum;
      logic [DDS_ACC_W:0] res;
      sum = {1'b0, ftw} + {delta[DDS_ACC_W-1], delta};
      res = {1'b0, sum[DDS_ACC_W-1:0]};
      if (sat_en && sum[DDS_ACC_W]) begin
         if (delta[DDS_ACC_W-1]) begin
            res = {1'b1, {DDS_ACC_W{1'b0}}};
         end else begin
            res = {1'b1, {DDS_ACC_W{1'b1}}};
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/dds_phase_acc.sv
// Phase accumulator with registered top-bit output feeding the sine LUT.
module dds_phase_acc
   import dds_pkg::*;
#(
   parameter int unsigned ACC_W = DDS_ACC_W,
   parameter int unsigned OUT_W = DDS_OUT_W
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [ACC_W-1:0] ftw,
   input  logic             clr,
   input  logic             en,
   output logic [OUT_W-1:0] phase_out
);

   logic [ACC_W-1:0] acc_q, acc_d;
   logic [OUT_W-1:0] out_q, out_d;

   // Clear also zeroes the output so PHASE_OUT reads 0 once the burst ends.
   always_comb begin
      acc_d = acc_q;
      out_d = acc_q[ACC_W-1 -: OUT_W];
      if (clr) begin
         acc_d = '0;
         out_d = '0;
      end else if (en) begin
         acc_d = acc_q + ftw;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         acc_q <= '0;
         out_q <= '0;
      end else begin
         acc_q <= acc_d;
         out_q <= out_d;
      end
   end

   assign phase_out = out_q;

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Linear-FM sweep controller: burst FSM, step timer and tuning-word update
// driving a phase accumulator for the on-chip DDS.
module dds_sweep_ctrl
   import dds_pkg::*;
#(
   parameter int unsigned ACC_W  = DDS_ACC_W,
   parameter int unsigned OUT_W  = DDS_OUT_W,
   parameter bit          SAT_EN = 1'b1
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [ACC_W-1:0] DDS_freq,
   input  logic [ACC_W-1:0] DDS_delta_freq,
   input  logic [31:0]      DDS_delta_rate,
   input  logic             DDS_start,
   output logic [ACC_W-1:0] FTW,
   output logic [OUT_W-1:0] PHASE_OUT,
   output logic             SWEEP_ACTIVE,
   output logic [31:0]      STEP_CNT,
   output logic             SAT_FLAG
);

   dds_state_e          state_q, state_d;
   logic                start_q, start_d;
   logic                armed_q, armed_d;
   logic                pend_q, pend_d;
   logic [ACC_W-1:0]    ftw_q, ftw_d;
   dds_step_cfg_t       cfg_q, cfg_d;
   logic [31:0]         rate_cnt_q, rate_cnt_d;
   logic [31:0]         step_cnt_q, step_cnt_d;
   logic                sat_flag_q, sat_flag_d;
   logic                active_q, active_d;

   logic                rise_c;
   logic [DDS_ACC_W:0]  step_c;
   logic                acc_clr_c;
   logic                acc_en_c;

   // Next-state, step timer and tuning-word update.
   always_comb begin
      state_d    = state_q;
      start_d    = DDS_start;
      armed_d    = armed_q | ~DDS_start;
      pend_d     = pend_q;
      ftw_d      = ftw_q;
      cfg_d      = cfg_q;
      rate_cnt_d = rate_cnt_q;
      step_cnt_d = step_cnt_q;
      sat_flag_d = sat_flag_q;
      acc_clr_c  = 1'b0;
      acc_en_c   = 1'b0;

      // A gate held high through reset must drop once before it can start a burst.
      rise_c = DDS_start & ~start_q & armed_q;
      step_c = sat_add(DDS_ACC_W'(ftw_q), cfg_q.delta, SAT_EN);

      case (state_q)
         IDLE: begin
            pend_d = 1'b0;
            if (rise_c || (pend_q && DDS_start)) begin
               state_d = LOAD;
            end
         end
         LOAD: begin
            ftw_d      = DDS_freq;
            cfg_d      = '{delta: DDS_ACC_W'(DDS_delta_freq), rate: DDS_delta_rate};
            rate_cnt_d = DDS_delta_rate;
            step_cnt_d = '0;
            sat_flag_d = 1'b0;
            acc_clr_c  = 1'b1;
            state_d    = RUN;
         end
         RUN: begin
            acc_en_c = 1'b1;
            if (cfg_q.rate != 32'd0) begin
               if (rate_cnt_q != 32'd0) begin
                  rate_cnt_d = rate_cnt_q - 32'd1;
               end else begin
                  ftw_d      = ACC_W'(step_c[DDS_ACC_W-1:0]);
                  rate_cnt_d = cfg_q.rate;
                  step_cnt_d = step_cnt_q + 32'd1;
                  sat_flag_d = sat_flag_q | step_c[DDS_ACC_W];
               end
            end
            if (!DDS_start) begin
               state_d = STOP;
            end
         end
         STOP: begin
            // A restart arriving during the single STOP cycle is honoured from IDLE.
            ftw_d     = '0;
            acc_clr_c = 1'b1;
            if (rise_c) begin
               pend_d = 1'b1;
            end
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      active_d = (state_d == RUN);
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q    <= IDLE;
         start_q    <= 1'b0;
         armed_q    <= 1'b0;
         pend_q     <= 1'b0;
         ftw_q      <= '0;
         cfg_q      <= '0;
         rate_cnt_q <= '0;
         step_cnt_q <= '0;
         sat_flag_q <= 1'b0;
         active_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         start_q    <= start_d;
         armed_q    <= armed_d;
         pend_q     <= pend_d;
         ftw_q      <= ftw_d;
         cfg_q      <= cfg_d;
         rate_cnt_q <= rate_cnt_d;
         step_cnt_q <= step_cnt_d;
         sat_flag_q <= sat_flag_d;
         active_q   <= active_d;
      end
   end

   // Phase runs on the tuning word registered before any same-cycle step.
   dds_phase_acc #(
      .ACC_W (ACC_W),
      .OUT_W (OUT_W)
   ) u_phase_acc (
      .CLK       (CLK),
      .RESET     (RESET),
      .ftw       (ftw_q),
      .clr       (acc_clr_c),
      .en        (acc_en_c),
      .phase_out (PHASE_OUT)
   );

   assign FTW          = ftw_q;
   assign SWEEP_ACTIVE = active_q;
   assign STEP_CNT     = step_cnt_q;
   assign SAT_FLAG     = sat_flag_q;

endmodule
